// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: memory-stall FSM encoding and the
// default register-index type.
package hazard_scoreboard_pkg;

    localparam int NREGS_DEF = 32;
    localparam int REG_W_DEF = $clog2(NREGS_DEF);

    typedef logic [REG_W_DEF-1:0] regbits_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter used for the stall performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Count enabled cycles, holding at all-ones once reached.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: register busy scoreboard, multiplier occupancy
// counter and data-cache miss freeze FSM, producing pipeline enables/bubbles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int REG_W   = $clog2(NREGS),
    parameter int MUL_LAT = 4,
    parameter bit FWD_EN  = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             id_is_mul,
    input  logic             flush,
    input  logic             mem_req,
    input  logic             dhit,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             hazard_detected,
    output logic [NREGS-1:0] busy_vec,
    output logic             mul_busy,
    output logic [CNT_W-1:0] raw_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt
);

    localparam int MCNT_W = $clog2(MUL_LAT + 1);
    localparam logic [MCNT_W-1:0] MUL_LOAD = MCNT_W'(MUL_LAT);

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic              freeze;
    logic [MCNT_W-1:0] mul_cnt;
    logic [NREGS-1:0]  clear_mask;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  busy_eff;
    logic              raw;
    logic              waw;
    logic              struct_haz;
    logic              stall_h;
    logic              issue;
    logic              tracked_producer;

    // Writeback clear mask; r0 is never tracked so a write to it clears nothing.
    always_comb begin
        clear_mask = '0;
        if (wb_valid && (wb_rd != '0)) begin
            clear_mask[wb_rd] = 1'b1;
        end
    end

    // Same-cycle writeback already satisfies the consumer, so checks use busy_eff.
    assign busy_eff   = busy_vec & ~clear_mask;
    assign raw        = (id_rs1_used && busy_eff[id_rs1]) || (id_rs2_used && busy_eff[id_rs2]);
    assign waw        = id_regwrite && busy_eff[id_rd];
    assign struct_haz = id_is_mul && (mul_cnt != '0);
    assign stall_h    = id_valid && (raw || waw || struct_haz);
    assign issue      = id_valid && !freeze && !flush && !stall_h;

    // With forwarding only long-latency producers need tracking.
    assign tracked_producer = !FWD_EN || id_is_load || id_is_mul;

    // Scoreboard set mask for the instruction leaving ID this cycle.
    always_comb begin
        set_mask = '0;
        if (issue && id_regwrite && (id_rd != '0) && tracked_producer) begin
            set_mask[id_rd] = 1'b1;
        end
    end

    // Busy scoreboard: clears always apply, a same-cycle set wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_eff | set_mask;
        end
    end

    // Multiplier occupancy: reload on mul issue, otherwise drain even while frozen.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mul_cnt <= '0;
        end else if (issue && id_is_mul) begin
            mul_cnt <= MUL_LOAD;
        end else if (mul_cnt != '0) begin
            mul_cnt <= mul_cnt - MCNT_W'(1);
        end
    end

    assign mul_busy = (mul_cnt != '0);

    // Memory-stall FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory-stall FSM next state; a hit in MEM_WAIT releases the freeze at once.
    always_comb begin
        state_nxt = state;
        freeze    = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !dhit) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dhit) begin
                    state_nxt = RUN;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Pipeline control with priority freeze > flush > hazard stall.
    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        id_ex_bubble    = 1'b0;
        pipe_freeze     = 1'b0;
        hazard_detected = 1'b0;
        if (freeze) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (flush) begin
            id_ex_bubble = 1'b1;
        end else if (stall_h) begin
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            id_ex_bubble    = 1'b1;
            hazard_detected = 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_raw_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (hazard_detected),
        .cnt  (raw_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (pipe_freeze),
        .cnt  (mem_stall_cnt)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expected responses,
// a monitor on the falling edge pops and compares them.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00101;
    localparam logic [4:0] FRZ   = 5'b00010;
    localparam logic [4:0] FLUSH = 5'b11100;

    logic CLK;
    logic nRST;
    logic id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_is_load, id_is_mul;
    regbits_t id_rs1, id_rs2, id_rd, wb_rd;
    logic flush, mem_req, dhit, wb_valid;
    logic sat_en;
    logic [1:0] sat_cnt;

    logic pc_write, if_id_write, id_ex_bubble, pipe_freeze, hazard_detected, mul_busy;
    logic [31:0] busy_vec, raw_stall_cnt, mem_stall_cnt;
    logic pc_write0, if_id_write0, id_ex_bubble0, pipe_freeze0, hazard_detected0, mul_busy0;
    logic [31:0] busy_vec0, raw_stall_cnt0, mem_stall_cnt0;

    typedef struct {
        string       name;
        int          which;
        logic [4:0]  ctl;
        logic [31:0] busy;
        logic        mb;
        int          rc;
        int          mc;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(.NREGS(32), .MUL_LAT(4), .FWD_EN(1'b1), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
        .flush(flush), .mem_req(mem_req), .dhit(dhit), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .pipe_freeze(pipe_freeze), .hazard_detected(hazard_detected), .busy_vec(busy_vec),
        .mul_busy(mul_busy), .raw_stall_cnt(raw_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
    );

    hazard_scoreboard #(.NREGS(32), .MUL_LAT(4), .FWD_EN(1'b0), .CNT_W(32)) dut0 (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
        .flush(flush), .mem_req(mem_req), .dhit(dhit), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .pc_write(pc_write0), .if_id_write(if_id_write0), .id_ex_bubble(id_ex_bubble0),
        .pipe_freeze(pipe_freeze0), .hazard_detected(hazard_detected0), .busy_vec(busy_vec0),
        .mul_busy(mul_busy0), .raw_stall_cnt(raw_stall_cnt0), .mem_stall_cnt(mem_stall_cnt0)
    );

    sat_counter #(.CNT_W(2)) u_sat (
        .CLK(CLK), .nRST(nRST), .en(sat_en), .cnt(sat_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: compare every queued expectation against the DUT on the falling edge.
    exp_t        e;
    logic [4:0]  act_ctl;
    logic [31:0] act_busy;
    logic        act_mb;
    int          act_rc, act_mc;
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (e.which == 2) begin
                if (sat_cnt !== 2'(e.rc)) begin
                    failures++;
                    $display("FAIL %s: sat_cnt=%0d required %0d", e.name, sat_cnt, e.rc);
                end
            end else begin
                if (e.which == 0) begin
                    act_ctl  = {pc_write, if_id_write, id_ex_bubble, pipe_freeze, hazard_detected};
                    act_busy = busy_vec;
                    act_mb   = mul_busy;
                    act_rc   = int'(raw_stall_cnt);
                    act_mc   = int'(mem_stall_cnt);
                end else begin
                    act_ctl  = {pc_write0, if_id_write0, id_ex_bubble0, pipe_freeze0, hazard_detected0};
                    act_busy = busy_vec0;
                    act_mb   = mul_busy0;
                    act_rc   = int'(raw_stall_cnt0);
                    act_mc   = int'(mem_stall_cnt0);
                end
                if (act_ctl !== e.ctl || act_busy !== e.busy || act_mb !== e.mb ||
                    act_rc != e.rc || act_mc != e.mc) begin
                    failures++;
                    $display("FAIL %s: ctl=%b busy=%h mul_busy=%b raw=%0d mem=%0d required ctl=%b busy=%h mul_busy=%b raw=%0d mem=%0d",
                             e.name, act_ctl, act_busy, act_mb, act_rc, act_mc,
                             e.ctl, e.busy, e.mb, e.rc, e.mc);
                end
            end
        end
    end

    task automatic push(input string n, input int w, input logic [4:0] c,
                        input logic [31:0] b, input logic mb, input int rc, input int mc);
        exp_t x;
        x.name = n; x.which = w; x.ctl = c; x.busy = b; x.mb = mb; x.rc = rc; x.mc = mc;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = '0; id_regwrite = 0; id_is_load = 0; id_is_mul = 0;
        flush = 0; mem_req = 0; dhit = 0; wb_valid = 0; wb_rd = '0;
    endtask

    task automatic id_instr(input int rs1, input bit u1, input int rs2, input bit u2,
                            input int rd, input bit rw, input bit ld, input bit mul);
        id_valid = 1; id_rs1 = regbits_t'(rs1); id_rs1_used = u1;
        id_rs2 = regbits_t'(rs2); id_rs2_used = u2; id_rd = regbits_t'(rd);
        id_regwrite = rw; id_is_load = ld; id_is_mul = mul;
    endtask

    task automatic wb(input int rd);
        wb_valid = 1; wb_rd = regbits_t'(rd);
    endtask

    initial begin
        nRST = 0; sat_en = 0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        push("reset", 0, NORM, 32'h0, 0, 0, 0);
        push("reset_f0", 1, NORM, 32'h0, 0, 0, 0);

        // Load-use on r5
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 5, 1, 1, 0);
        push("ld5_issue", 0, NORM, 32'h0, 0, 0, 0);
        step(); idle_inputs(); id_instr(5, 1, 0, 0, 6, 1, 0, 0);
        push("lu_stall1", 0, STALL, 32'h20, 0, 0, 0);
        step(); idle_inputs(); id_instr(5, 1, 0, 0, 6, 1, 0, 0);
        push("lu_stall2", 0, STALL, 32'h20, 0, 1, 0);
        step(); idle_inputs(); id_instr(5, 1, 0, 0, 6, 1, 0, 0); wb(5);
        push("lu_wb", 0, NORM, 32'h20, 0, 2, 0);
        step(); idle_inputs();
        push("lu_clear", 0, NORM, 32'h0, 0, 2, 0);

        // Same-cycle set and clear of r7
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 7, 1, 1, 0);
        push("ld7_issue", 0, NORM, 32'h0, 0, 2, 0);
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 7, 1, 1, 0); wb(7);
        push("setclr", 0, NORM, 32'h80, 0, 2, 0);
        step(); idle_inputs();
        push("setclr_next", 0, NORM, 32'h80, 0, 2, 0);
        step(); idle_inputs(); wb(7);

        // Multiplier structural hazard
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 8, 1, 0, 1);
        push("mul_issue", 0, NORM, 32'h0, 0, 2, 0);
        for (int k = 1; k <= 4; k++) begin
            step(); idle_inputs(); id_instr(0, 0, 0, 0, 9, 1, 0, 1);
            push($sformatf("mul_stall%0d", k), 0, STALL, 32'h100, 1, 1 + k, 0);
        end
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 9, 1, 0, 1);
        push("mul_go", 0, NORM, 32'h100, 0, 6, 0);
        step(); idle_inputs();
        push("mul_reload", 0, NORM, 32'h300, 1, 6, 0);
        step(); idle_inputs(); wb(8);
        step(); idle_inputs(); wb(9);
        step(); idle_inputs();

        // Cache miss with a masked RAW stall
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 5, 1, 1, 0);
        push("ld5b", 0, NORM, 32'h0, 0, 6, 0);
        for (int k = 1; k <= 3; k++) begin
            step(); idle_inputs(); mem_req = 1; dhit = 0; id_instr(5, 1, 0, 0, 6, 1, 0, 0);
            push($sformatf("miss%0d", k), 0, FRZ, 32'h20, 0, 6, k - 1);
        end
        step(); idle_inputs(); mem_req = 1; dhit = 1; id_instr(5, 1, 0, 0, 6, 1, 0, 0);
        push("miss_end", 0, STALL, 32'h20, 0, 6, 3);
        step(); idle_inputs(); id_instr(5, 1, 0, 0, 6, 1, 0, 0); wb(5);
        push("miss_wb", 0, NORM, 32'h20, 0, 7, 3);
        step(); idle_inputs(); mem_req = 1; dhit = 1;
        push("hit_run", 0, NORM, 32'h0, 0, 7, 3);

        // Flush beats a RAW stall and sets nothing
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 5, 1, 1, 0);
        push("ld5c", 0, NORM, 32'h0, 0, 7, 3);
        step(); idle_inputs(); flush = 1; id_instr(5, 1, 0, 0, 10, 1, 1, 0);
        push("flush_raw", 0, FLUSH, 32'h20, 0, 7, 3);
        step(); idle_inputs(); wb(5);
        push("flush_noset", 0, NORM, 32'h20, 0, 7, 3);
        step(); idle_inputs();
        push("flush_clear", 0, NORM, 32'h0, 0, 7, 3);

        // Freeze beats flush, then asynchronous reset mid-miss and mid-multiply
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 5, 1, 0, 1);
        push("mul5", 0, NORM, 32'h0, 0, 7, 3);
        step(); idle_inputs();
        step(); idle_inputs(); mem_req = 1; dhit = 0; flush = 1;
        push("frz_flush", 0, FRZ, 32'h20, 1, 7, 3);
        step(); idle_inputs();
        push("mem_wait", 0, FRZ, 32'h20, 1, 7, 4);
        @(negedge CLK);
        #1 nRST = 0;
        #2 nRST = 1;
        step(); idle_inputs();
        push("async_rst", 0, NORM, 32'h0, 0, 0, 0);
        push("async_rst_f0", 1, NORM, 32'h0, 0, 0, 0);

        // No forwarding: plain ALU producers are tracked
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 3, 1, 0, 0);
        push("f0_add", 1, NORM, 32'h0, 0, 0, 0);
        step(); idle_inputs(); id_instr(3, 1, 0, 0, 4, 1, 0, 0);
        push("f0_stall1", 1, STALL, 32'h08, 0, 0, 0);
        push("f1_nostall", 0, NORM, 32'h0, 0, 0, 0);
        step(); idle_inputs(); id_instr(3, 1, 0, 0, 4, 1, 0, 0);
        push("f0_stall2", 1, STALL, 32'h08, 0, 1, 0);
        step(); idle_inputs(); id_instr(3, 1, 0, 0, 4, 1, 0, 0); wb(3);
        push("f0_wb", 1, NORM, 32'h08, 0, 2, 0);
        step(); idle_inputs();
        push("f0_after", 1, NORM, 32'h10, 0, 2, 0);
        step(); idle_inputs(); id_instr(0, 0, 4, 1, 11, 1, 0, 0);
        push("f0_rs2", 1, STALL, 32'h10, 0, 2, 0);
        step(); idle_inputs(); id_instr(0, 0, 0, 0, 4, 1, 0, 0);
        push("f0_waw", 1, STALL, 32'h10, 0, 3, 0);
        push("f1_waw_none", 0, NORM, 32'h0, 0, 0, 0);

        // Saturating counter holds at all-ones
        step(); idle_inputs(); sat_en = 1;
        step();
        step();
        push("sat_mid", 2, NORM, 32'h0, 0, 2, 0);
        step();
        step();
        push("sat_top", 2, NORM, 32'h0, 0, 3, 0);

        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
